wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 125 ++++++++++++
 tb/tb_wb_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: write-back buffer between the MEM stage and the register file.
//
// Results from MEM are queued in an in-order FIFO of DEPTH entries (2 or 4).
// The head entry drives the register-file write port unless the port is held.
// Entries that do not write (wb_en=0 or dest=0) still drain, one per cycle,
// without a write strobe. A combinational hazard output tells decode when one
// of its sources is still waiting in the buffer.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   in_valid / in_ready   MEM-side handshake
//   in_wb_en, in_mem_r_en, in_dest, in_alu_result, in_mem_data
//                         result fields; load data is chosen at enqueue
//   wb_hold               register-file write port unavailable this cycle
//   WB_Write_Enable, WB_Dest, WB_Data
//                         register-file write port
//   hz_src1, hz_src2, hz_single_src, wb_hazard
//                         decode-stage dependency check
//   count                 occupied buffer entries
module wb_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wb_en,
  input  logic        in_mem_r_en,
  input  logic [4:0]  in_dest,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_mem_data,
  input  logic        wb_hold,
  output logic        WB_Write_Enable,
  output logic [4:0]  WB_Dest,
  output logic [31:0] WB_Data,
  input  logic [4:0]  hz_src1,
  input  logic [4:0]  hz_src2,
  input  logic        hz_single_src,
  output logic        wb_hazard,
  output logic [2:0]  count
);

  // DEPTH is a power of two, so pointers wrap naturally in PW bits.
  localparam int PW = (DEPTH == 4) ? 2 : 1;

  logic          ent_wb_en [DEPTH];
  logic [4:0]    ent_dest  [DEPTH];
  logic [31:0]   ent_data  [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [2:0]    cnt;

  logic          push;
  logic          pop;
  logic          not_empty;
  logic          hazard_c;

  assign not_empty = (cnt != 3'd0);
  assign in_ready  = (cnt < 3'(DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = not_empty && !wb_hold;
  assign count     = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_wb_en[i] <= 1'b0;
        ent_dest[i]  <= 5'd0;
        ent_data[i]  <= 32'd0;
      end
    end else begin
      if (push) begin
        ent_wb_en[wr_ptr] <= in_wb_en;
        ent_dest[wr_ptr]  <= in_dest;
        ent_data[wr_ptr]  <= in_mem_r_en ? in_mem_data : in_alu_result;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Write port: head entry when something is buffered, zero otherwise.
  always_comb begin
    WB_Write_Enable = 1'b0;
    WB_Dest         = 5'd0;
    WB_Data         = 32'd0;
    if (not_empty) begin
      WB_Dest         = ent_dest[rd_ptr];
      WB_Data         = ent_data[rd_ptr];
      WB_Write_Enable = !wb_hold && ent_wb_en[rd_ptr] && (ent_dest[rd_ptr] != 5'd0);
    end
  end

  // An entry is occupied when its distance from the head is below cnt.
  // The head being written this cycle is still occupied, since decode reads
  // the register file in the same cycle and would miss the new value.
  always_comb begin
    logic [PW-1:0] off;
    off      = '0;
    hazard_c = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if ((3'(off) < cnt) && ent_wb_en[i] && (ent_dest[i] != 5'd0)) begin
        if ((ent_dest[i] == hz_src1) ||
            (!hz_single_src && (ent_dest[i] == hz_src2))) begin
          hazard_c = 1'b1;
        end
      end
    end
  end

  assign wb_hazard = hazard_c;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wb_en;
  logic        in_mem_r_en;
  logic [4:0]  in_dest;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_data;
  logic        wb_hold;
  logic        WB_Write_Enable;
  logic [4:0]  WB_Dest;
  logic [31:0] WB_Data;
  logic [4:0]  hz_src1;
  logic [4:0]  hz_src2;
  logic        hz_single_src;
  logic        wb_hazard;
  logic [2:0]  count;

  wb_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_dest(in_dest),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .wb_hold(wb_hold),
    .WB_Write_Enable(WB_Write_Enable), .WB_Dest(WB_Dest), .WB_Data(WB_Data),
    .hz_src1(hz_src1), .hz_src2(hz_src2), .hz_single_src(hz_single_src),
    .wb_hazard(wb_hazard), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain queue of results.
  typedef struct {
    logic        wb_en;
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
    end else begin
      ent_t e;
      bit   do_push;
      do_push = in_valid && (q.size() < DEPTH);
      e.wb_en = in_wb_en;
      e.dest  = in_dest;
      e.data  = in_mem_r_en ? in_mem_data : in_alu_result;
      if (q.size() > 0 && !wb_hold) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  end

  // Compare every cycle, mid-period.
  always @(negedge clk) begin
    logic        e_we, e_hz;
    logic [4:0]  e_dest;
    logic [31:0] e_data;
    e_we = 1'b0; e_dest = 5'd0; e_data = 32'd0; e_hz = 1'b0;
    if (q.size() > 0) begin
      e_dest = q[0].dest;
      e_data = q[0].data;
      e_we   = !wb_hold && q[0].wb_en && (q[0].dest != 5'd0);
    end
    foreach (q[i])
      if (q[i].wb_en && q[i].dest != 5'd0 &&
          (q[i].dest == hz_src1 || (!hz_single_src && q[i].dest == hz_src2)))
        e_hz = 1'b1;
    check("cmp_count",  32'(count),           32'(q.size()));
    check("cmp_ready",  32'(in_ready),        32'(q.size() < DEPTH));
    check("cmp_we",     32'(WB_Write_Enable), 32'(e_we));
    check("cmp_dest",   32'(WB_Dest),         32'(e_dest));
    check("cmp_data",   WB_Data,              e_data);
    check("cmp_hazard", 32'(wb_hazard),       32'(e_hz));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic mr, input logic [4:0] d,
                       input logic [31:0] alu, input logic [31:0] md);
    in_valid = v; in_wb_en = we; in_mem_r_en = mr; in_dest = d;
    in_alu_result = alu; in_mem_data = md;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before t=100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; wb_hold = 1'b0;
    hz_src1 = 5'd0; hz_src2 = 5'd0; hz_single_src = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step(); step();
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(in_ready), 1);
    rst = 1'b1;

    // Single ALU result
    drive(1, 1, 0, 5'd5, 32'h1234, 32'h0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("alu_we",   32'(WB_Write_Enable), 1);
    check("alu_dest", 32'(WB_Dest), 5);
    check("alu_data", WB_Data, 32'h1234);
    step();
    check("alu_drained", 32'(count), 0);

    // Load select to $0: no write, one-cycle drain
    drive(1, 1, 1, 5'd0, 32'h55, 32'hDEADBEEF);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("ld0_we",   32'(WB_Write_Enable), 0);
    check("ld0_data", WB_Data, 32'hDEADBEEF);
    check("ld0_cnt",  32'(count), 1);
    step();
    check("ld0_drained", 32'(count), 0);

    // Backpressure: third push ignored, then two ordered writes
    wb_hold = 1'b1;
    drive(1, 1, 0, 5'd1, 32'h11, 0); step();
    drive(1, 1, 0, 5'd2, 32'h22, 0); step();
    check("bp_full_ready", 32'(in_ready), 0);
    drive(1, 1, 0, 5'd3, 32'h33, 0); step();
    check("bp_full_cnt", 32'(count), 2);
    drive(0, 0, 0, 0, 0, 0);
    wb_hold = 1'b0;
    #1;
    check("bp_w1_dest", 32'(WB_Dest), 1);
    check("bp_w1_data", WB_Data, 32'h11);
    check("bp_w1_we",   32'(WB_Write_Enable), 1);
    step();
    check("bp_w2_dest", 32'(WB_Dest), 2);
    check("bp_w2_data", WB_Data, 32'h22);
    step();
    check("bp_empty", 32'(count), 0);

    // Full with push+pop: push ignored, one pop
    wb_hold = 1'b1;
    drive(1, 1, 0, 5'd4, 32'h44, 0); step();
    drive(1, 1, 0, 5'd6, 32'h66, 0); step();
    wb_hold = 1'b0;
    drive(1, 1, 0, 5'd9, 32'h99, 0);
    #1;
    check("fpp_ready", 32'(in_ready), 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("fpp_cnt",  32'(count), 1);
    check("fpp_dest", 32'(WB_Dest), 6);
    // Push while popping at count=1 keeps count and order (pointer wrap)
    drive(1, 1, 0, 5'd10, 32'hA0, 0); step();
    check("pp_cnt",  32'(count), 1);
    check("pp_dest", 32'(WB_Dest), 10);
    drive(1, 1, 0, 5'd11, 32'hB0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("pp2_data", WB_Data, 32'hB0);
    step();

    // Hazard
    wb_hold = 1'b1;
    drive(1, 1, 0, 5'd7, 32'h77, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    hz_src1 = 5'd3; hz_src2 = 5'd7; hz_single_src = 1'b0;
    #1; check("hz_src2", 32'(wb_hazard), 1);
    hz_single_src = 1'b1;
    #1; check("hz_single", 32'(wb_hazard), 0);
    wb_hold = 1'b0; step();
    wb_hold = 1'b1;
    drive(1, 1, 0, 5'd0, 32'h1, 0); step();
    drive(1, 0, 0, 5'd7, 32'h2, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    hz_src1 = 5'd0; hz_src2 = 5'd7; hz_single_src = 1'b0;
    #1; check("hz_r0_noen", 32'(wb_hazard), 0);
    wb_hold = 1'b0;
    #1; check("noen_we", 32'(WB_Write_Enable), 0);
    step(); step();
    check("hz_drained", 32'(count), 0);

    // Reset mid-stream, asynchronous
    wb_hold = 1'b1;
    drive(1, 1, 0, 5'd8, 32'h88, 0); step();
    drive(1, 1, 0, 5'd9, 32'h99, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    wb_hold = 1'b0;
    hz_src1 = 5'd8;
    #1;
    rst = 1'b0;
    #1;
    check("arst_count",  32'(count), 0);
    check("arst_we",     32'(WB_Write_Enable), 0);
    check("arst_dest",   32'(WB_Dest), 0);
    check("arst_data",   WB_Data, 0);
    check("arst_hazard", 32'(wb_hazard), 0);
    check("arst_ready",  32'(in_ready), 1);
    step();
    rst = 1'b1;
    drive(1, 1, 0, 5'd12, 32'hABC, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("post_we",   32'(WB_Write_Enable), 1);
    check("post_dest", 32'(WB_Dest), 12);
    check("post_data", WB_Data, 32'hABC);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
